// File: rtl/dsdmnist_resultbuf_arbiter.sv
// Single-port result-buffer arbiter: accelerator owns the RAM combinationally, host reads fill idle cycles (ACK 2 cycles after issue).
// Accelerator writes are snooped to emit a per-image argmax strobe one cycle after the class-9 write and flag out-of-order addresses.
module dsdmnist_resultbuf_arbiter #(
    parameter int IMGNUM = 10,
    localparam int OAW = $clog2(IMGNUM*10),
    localparam int IIW = $clog2(IMGNUM)
) (
    input  logic            i_CLK,
    input  logic            i_RST,
    input  logic            i_ACC_EN,
    input  logic            i_ACC_WE,
    input  logic [OAW-1:0]  i_ACC_ADDR,
    input  logic [31:0]     i_ACC_DATA,
    input  logic            i_HOST_REQ,
    input  logic [OAW-1:0]  i_HOST_ADDR,
    output logic            o_HOST_ACK,
    output logic [31:0]     o_HOST_DATA,
    output logic            o_RAM_EN,
    output logic            o_RAM_WE,
    output logic [OAW-1:0]  o_RAM_ADDR,
    output logic [31:0]     o_RAM_DATA,
    input  logic [31:0]     i_RAM_DOUT,
    output logic            o_CLS_VALID,
    output logic [IIW-1:0]  o_CLS_IMG,
    output logic [3:0]      o_CLS_DIGIT,
    output logic            o_SEQ_ERR
);

    localparam int NADDR = IMGNUM*10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RD,
        ST_ACK
    } host_st_e;

    host_st_e       st_q;
    logic           ack_q;
    logic [31:0]    hdata_q;
    logic           host_go;

    // Host only issues from IDLE in a cycle the accelerator leaves free; held off during reset.
    assign host_go = (st_q == ST_IDLE) && i_HOST_REQ && !i_ACC_EN && !i_RST;

    always_comb begin
        o_RAM_EN   = 1'b0;
        o_RAM_WE   = 1'b0;
        o_RAM_ADDR = '0;
        o_RAM_DATA = i_ACC_DATA;
        if (i_ACC_EN) begin
            o_RAM_EN   = 1'b1;
            o_RAM_WE   = i_ACC_WE;
            o_RAM_ADDR = i_ACC_ADDR;
        end else if (host_go) begin
            o_RAM_EN   = 1'b1;
            o_RAM_ADDR = i_HOST_ADDR;
        end
    end

    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            st_q    <= ST_IDLE;
            ack_q   <= 1'b0;
            hdata_q <= '0;
        end else begin
            ack_q <= 1'b0;
            unique case (st_q)
                ST_IDLE: if (host_go) st_q <= ST_RD;
                ST_RD: begin
                    hdata_q <= i_RAM_DOUT;
                    ack_q   <= 1'b1;
                    st_q    <= ST_ACK;
                end
                ST_ACK:  st_q <= ST_IDLE;
                default: st_q <= ST_IDLE;
            endcase
        end
    end

    assign o_HOST_ACK  = ack_q;
    assign o_HOST_DATA = hdata_q;

    logic [OAW-1:0]     exp_q, exp_d;
    logic [3:0]         cls_q, cls_d;
    logic [IIW-1:0]     img_q, img_d;
    logic signed [31:0] max_q, max_d;
    logic [3:0]         idx_q, idx_d;
    logic               clsv_q, clsv_d;
    logic [IIW-1:0]     clsimg_q, clsimg_d;
    logic [3:0]         clsdig_q, clsdig_d;
    logic               err_q, err_d;
    logic               acc_wr;
    logic               gt;

    assign acc_wr = i_ACC_EN & i_ACC_WE;
    assign gt     = $signed(i_ACC_DATA) > max_q;

    always_comb begin
        exp_d    = exp_q;
        cls_d    = cls_q;
        img_d    = img_q;
        max_d    = max_q;
        idx_d    = idx_q;
        clsv_d   = 1'b0;
        clsimg_d = clsimg_q;
        clsdig_d = clsdig_q;
        err_d    = err_q;
        if (acc_wr) begin
            if (i_ACC_ADDR != exp_q) err_d = 1'b1;
            exp_d = (exp_q == OAW'(NADDR-1)) ? '0 : exp_q + OAW'(1);
            // Strict compare keeps the lowest class on ties; class 0 always seeds the running max.
            if ((cls_q == 4'd0) || gt) begin
                max_d = i_ACC_DATA;
                idx_d = cls_q;
            end
            if (cls_q == 4'd9) begin
                clsv_d   = 1'b1;
                clsimg_d = img_q;
                clsdig_d = gt ? 4'd9 : idx_q;
                cls_d    = 4'd0;
                img_d    = (img_q == IIW'(IMGNUM-1)) ? '0 : img_q + IIW'(1);
            end else begin
                cls_d = cls_q + 4'd1;
            end
        end
    end

    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            exp_q    <= '0;
            cls_q    <= '0;
            img_q    <= '0;
            max_q    <= '0;
            idx_q    <= '0;
            clsv_q   <= 1'b0;
            clsimg_q <= '0;
            clsdig_q <= '0;
            err_q    <= 1'b0;
        end else begin
            exp_q    <= exp_d;
            cls_q    <= cls_d;
            img_q    <= img_d;
            max_q    <= max_d;
            idx_q    <= idx_d;
            clsv_q   <= clsv_d;
            clsimg_q <= clsimg_d;
            clsdig_q <= clsdig_d;
            err_q    <= err_d;
        end
    end

    assign o_CLS_VALID = clsv_q;
    assign o_CLS_IMG   = clsimg_q;
    assign o_CLS_DIGIT = clsdig_q;
    assign o_SEQ_ERR   = err_q;

endmodule

// File: tb/tb_dsdmnist_resultbuf_arbiter.sv
// Bench for dsdmnist_resultbuf_arbiter (IMGNUM=2): directed scenarios plus randomized traffic against a queue-based reference model.
module tb_dsdmnist_resultbuf_arbiter;

    localparam int IMG   = 2;
    localparam int OAW   = $clog2(IMG*10);
    localparam int IIW   = $clog2(IMG);
    localparam int NADDR = IMG*10;
    localparam int RAMD  = 1 << OAW;

    logic            i_CLK = 1'b0;
    logic            i_RST;
    logic            i_ACC_EN;
    logic            i_ACC_WE;
    logic [OAW-1:0]  i_ACC_ADDR;
    logic [31:0]     i_ACC_DATA;
    logic            i_HOST_REQ;
    logic [OAW-1:0]  i_HOST_ADDR;
    logic            o_HOST_ACK;
    logic [31:0]     o_HOST_DATA;
    logic            o_RAM_EN;
    logic            o_RAM_WE;
    logic [OAW-1:0]  o_RAM_ADDR;
    logic [31:0]     o_RAM_DATA;
    logic [31:0]     i_RAM_DOUT;
    logic            o_CLS_VALID;
    logic [IIW-1:0]  o_CLS_IMG;
    logic [3:0]      o_CLS_DIGIT;
    logic            o_SEQ_ERR;

    dsdmnist_resultbuf_arbiter #(.IMGNUM(IMG)) dut (
        .i_CLK(i_CLK), .i_RST(i_RST),
        .i_ACC_EN(i_ACC_EN), .i_ACC_WE(i_ACC_WE), .i_ACC_ADDR(i_ACC_ADDR), .i_ACC_DATA(i_ACC_DATA),
        .i_HOST_REQ(i_HOST_REQ), .i_HOST_ADDR(i_HOST_ADDR),
        .o_HOST_ACK(o_HOST_ACK), .o_HOST_DATA(o_HOST_DATA),
        .o_RAM_EN(o_RAM_EN), .o_RAM_WE(o_RAM_WE), .o_RAM_ADDR(o_RAM_ADDR), .o_RAM_DATA(o_RAM_DATA),
        .i_RAM_DOUT(i_RAM_DOUT),
        .o_CLS_VALID(o_CLS_VALID), .o_CLS_IMG(o_CLS_IMG), .o_CLS_DIGIT(o_CLS_DIGIT),
        .o_SEQ_ERR(o_SEQ_ERR)
    );

    always #5 i_CLK = ~i_CLK;

    // Single-port RAM with one-cycle read latency.
    logic [31:0] ram [RAMD];
    always @(posedge i_CLK) begin
        if (o_RAM_EN) begin
            if (o_RAM_WE) ram[o_RAM_ADDR] <= o_RAM_DATA;
            else          i_RAM_DOUT <= ram[o_RAM_ADDR];
        end
    end

    int pass_cnt = 0;
    int chk_cnt  = 0;
    int cyc      = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Reference model state: expectations for the registered outputs of the current cycle.
    logic [31:0]    mem_m [RAMD];
    int             issue_cyc;
    logic [31:0]    pend_dat;
    logic           ack_e, clsv_e, seq_e;
    logic [31:0]    hdat_e;
    logic [IIW-1:0] img_e;
    logic [3:0]     dig_e;
    int             wcount, img_cnt;
    logic [31:0]    vals[$];
    int             strobe_cnt = 0, ack_cnt = 0, wr_cnt = 0;
    int             stb_img[$], stb_dig[$];

    initial begin : compare
        logic host_go;
        int   best;
        issue_cyc = -10; pend_dat = '0;
        ack_e = 1'b0; clsv_e = 1'b0; seq_e = 1'b0; hdat_e = '0; img_e = '0; dig_e = '0;
        wcount = 0; img_cnt = 0;
        forever begin
            @(negedge i_CLK);
            cyc++;
            if (i_RST) begin
                ack_e = 1'b0; clsv_e = 1'b0; seq_e = 1'b0; hdat_e = '0; img_e = '0; dig_e = '0;
                issue_cyc = -10; wcount = 0; img_cnt = 0; vals.delete();
            end
            check("host_ack",    32'(o_HOST_ACK),  32'(ack_e));
            check("host_data",   o_HOST_DATA,      hdat_e);
            check("cls_valid",   32'(o_CLS_VALID), 32'(clsv_e));
            check("cls_img",     32'(o_CLS_IMG),   32'(img_e));
            check("cls_digit",   32'(o_CLS_DIGIT), 32'(dig_e));
            check("seq_err",     32'(o_SEQ_ERR),   32'(seq_e));

            host_go = !i_RST && i_HOST_REQ && !i_ACC_EN && (cyc >= issue_cyc + 3);
            check("ram_en",   32'(o_RAM_EN), 32'(i_ACC_EN | host_go));
            check("ram_we",   32'(o_RAM_WE), 32'(i_ACC_EN & i_ACC_WE));
            check("ram_addr", 32'(o_RAM_ADDR),
                  i_ACC_EN ? 32'(i_ACC_ADDR) : (host_go ? 32'(i_HOST_ADDR) : 32'd0));
            check("ram_data", o_RAM_DATA, i_ACC_DATA);

            if (o_CLS_VALID) begin
                strobe_cnt++;
                stb_img.push_back(int'(o_CLS_IMG));
                stb_dig.push_back(int'(o_CLS_DIGIT));
            end
            if (o_HOST_ACK) ack_cnt++;
            if (o_RAM_EN && o_RAM_WE) wr_cnt++;

            ack_e  = 1'b0;
            clsv_e = 1'b0;
            if (host_go) begin
                issue_cyc = cyc;
                pend_dat  = mem_m[int'(i_HOST_ADDR)];
            end
            if (!i_RST && cyc == issue_cyc + 1) begin
                ack_e  = 1'b1;
                hdat_e = pend_dat;
            end
            if (!i_RST && i_ACC_EN && i_ACC_WE) begin
                if (int'(i_ACC_ADDR) != wcount) seq_e = 1'b1;
                wcount = (wcount + 1) % NADDR;
                vals.push_back(i_ACC_DATA);
                if (vals.size() == 10) begin
                    best = 0;
                    for (int k = 1; k < 10; k++)
                        if ($signed(vals[k]) > $signed(vals[best])) best = k;
                    clsv_e  = 1'b1;
                    img_e   = IIW'(img_cnt);
                    dig_e   = 4'(best);
                    img_cnt = (img_cnt + 1) % IMG;
                    vals.delete();
                end
            end
            if (i_ACC_EN && i_ACC_WE) mem_m[int'(i_ACC_ADDR)] = i_ACC_DATA;
        end
    end

    task automatic step();
        @(posedge i_CLK);
        #1;
    endtask

    task automatic acc_write(input int a, input logic [31:0] d);
        i_ACC_EN = 1'b1; i_ACC_WE = 1'b1; i_ACC_ADDR = OAW'(a); i_ACC_DATA = d;
        step();
        i_ACC_EN = 1'b0; i_ACC_WE = 1'b0;
    endtask

    task automatic wait_ack(output int lat);
        lat = 0;
        while (!o_HOST_ACK && lat < 40) begin
            step();
            lat++;
        end
    endtask

    // Holds the request through `busy` accelerator-read cycles, then waits for ACK.
    task automatic host_read(input int a, input int busy, output logic [31:0] d, output int lat);
        int l2;
        i_HOST_REQ = 1'b1; i_HOST_ADDR = OAW'(a); lat = 0;
        for (int k = 0; k < busy; k++) begin
            i_ACC_EN = 1'b1; i_ACC_WE = 1'b0; i_ACC_ADDR = OAW'(k);
            step();
            lat++;
        end
        i_ACC_EN = 1'b0;
        wait_ack(l2);
        lat += l2;
        d = o_HOST_DATA;
        i_HOST_REQ = 1'b0;
        step();
    endtask

    int d045 [10] = '{5, -3, 7, 7, 2, 0, -100, 1, 6, 7};
    int d048 [10] = '{-50, -40, -7, -30, -7, -99, -8, int'(32'h8000_0000), -60, -9};

    initial begin : stim
        logic [31:0] d;
        int lat, s0, w0, a0, sq;
        i_RST = 1'b1; i_ACC_EN = 1'b0; i_ACC_WE = 1'b0; i_ACC_ADDR = '0; i_ACC_DATA = '0;
        i_HOST_REQ = 1'b0; i_HOST_ADDR = '0;
        repeat (3) step();
        check("rst_seq_err", 32'(o_SEQ_ERR), 32'd0);
        check("rst_ram_en",  32'(o_RAM_EN),  32'd0);
        i_RST = 1'b0;
        step();

        // Ten ordered writes; argmax ties resolve to the lowest class.
        s0 = strobe_cnt; w0 = wr_cnt;
        for (int k = 0; k < 10; k++) acc_write(k, 32'(d045[k]));
        step();
        check("dir_wr_count",  32'(wr_cnt - w0),     32'd10);
        check("dir_strobes",   32'(strobe_cnt - s0), 32'd1);
        check("dir_img",       32'(stb_img[s0]),     32'd0);
        check("dir_digit",     32'(stb_dig[s0]),     32'd2);
        check("dir_digit_hold", 32'(o_CLS_DIGIT),    32'd2);
        check("dir_seq_err",   32'(o_SEQ_ERR),       32'd0);

        // Uncontended host read of address 3.
        i_HOST_REQ = 1'b1; i_HOST_ADDR = OAW'(3);
        #1;
        check("hr_issue_en",   32'(o_RAM_EN),   32'd1);
        check("hr_issue_we",   32'(o_RAM_WE),   32'd0);
        check("hr_issue_addr", 32'(o_RAM_ADDR), 32'd3);
        host_read(3, 0, d, lat);
        check("hr_latency", 32'(lat), 32'd2);
        check("hr_data",    d,        32'd7);
        check("hr_hold",    o_HOST_DATA, 32'd7);

        // Host starved by four accelerator cycles.
        host_read(2, 4, d, lat);
        check("cont_latency", 32'(lat), 32'd6);
        check("cont_data",    d,        32'd7);

        // Reset during RD aborts the read; the held request then completes afresh.
        a0 = ack_cnt;
        i_HOST_REQ = 1'b1; i_HOST_ADDR = OAW'(3);
        step();
        i_RST = 1'b1;
        #1;
        check("rrd_ack",   32'(o_HOST_ACK),  32'd0);
        check("rrd_data",  o_HOST_DATA,      32'd0);
        check("rrd_digit", 32'(o_CLS_DIGIT), 32'd0);
        check("rrd_ram_en", 32'(o_RAM_EN),   32'd0);
        step();
        i_RST = 1'b0;
        wait_ack(lat);
        check("rrd_no_early_ack", 32'(ack_cnt - a0), 32'd0);
        check("rrd_latency", 32'(lat), 32'd2);
        check("rrd_data2",   o_HOST_DATA, 32'd7);
        i_HOST_REQ = 1'b0;
        step();

        // Two full images of negative values, then the address counter wraps.
        s0 = strobe_cnt;
        for (int k = 0; k < 10; k++) acc_write(k, 32'(d048[k]));
        for (int k = 0; k < 10; k++) acc_write(10 + k, 32'(-100 + k));
        acc_write(0, 32'hFFFF_FFFF);
        step();
        check("wrap_strobes", 32'(strobe_cnt - s0), 32'd2);
        check("wrap_img0",    32'(stb_img[s0]),     32'd0);
        check("wrap_dig0",    32'(stb_dig[s0]),     32'd2);
        check("wrap_img1",    32'(stb_img[s0+1]),   32'd1);
        check("wrap_dig1",    32'(stb_dig[s0+1]),   32'd9);
        check("wrap_seq_err", 32'(o_SEQ_ERR),       32'd0);

        // Out-of-order write at the fifth position.
        i_RST = 1'b1; step(); i_RST = 1'b0; step();
        s0 = strobe_cnt;
        for (int k = 0; k < 10; k++) begin
            if (k == 4) check("ooo_before", 32'(o_SEQ_ERR), 32'd0);
            acc_write((k == 4) ? 5 : k, 32'(k * 3 - 10));
            if (k == 4) check("ooo_after", 32'(o_SEQ_ERR), 32'd1);
        end
        step();
        check("ooo_strobe", 32'(strobe_cnt - s0), 32'd1);
        check("ooo_sticky", 32'(o_SEQ_ERR),       32'd1);

        // Randomized traffic with occasional resets and misaddressed writes.
        i_RST = 1'b1; step(); i_RST = 1'b0;
        sq = 0;
        for (int n = 0; n < 3000; n++) begin
            i_RST    = ($urandom_range(0, 399) == 0);
            i_ACC_EN = ($urandom_range(0, 99) < 45);
            i_ACC_WE = ($urandom_range(0, 3) != 0);
            if (i_ACC_EN && i_ACC_WE) begin
                if ($urandom_range(0, 39) == 0) i_ACC_ADDR = OAW'($urandom_range(0, NADDR-1));
                else                            i_ACC_ADDR = OAW'(sq);
                sq = (sq + 1) % NADDR;
            end else begin
                i_ACC_ADDR = OAW'($urandom_range(0, NADDR-1));
            end
            if (i_RST) sq = 0;
            i_ACC_DATA = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 15)) - 32'd8;
            if (i_HOST_REQ && o_HOST_ACK) begin
                i_HOST_REQ = 1'b0;
            end else if (!i_HOST_REQ && $urandom_range(0, 3) == 0) begin
                i_HOST_REQ  = 1'b1;
                i_HOST_ADDR = OAW'($urandom_range(0, NADDR-1));
            end
            step();
        end
        i_RST = 1'b0; i_ACC_EN = 1'b0; i_HOST_REQ = 1'b0;
        repeat (4) step();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", pass_cnt, chk_cnt);
        $fatal(1);
    end

endmodule
